// File: rtl/vec_mac_if.sv
// vec_mac_if: load, control and readback signals of the vector MAC engine
interface vec_mac_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int ACCW  = 2*DW+16
);
    localparam int AW = $clog2(DEPTH);
    logic            we;
    logic            category;
    logic [AW-1:0]   index;
    logic [DW-1:0]   a_data;
    logic [DW-1:0]   b_data;
    logic [AW:0]     n;
    logic            mode;
    logic            start;
    logic [AW-1:0]   rd_index;
    logic [ACCW-1:0] c_data_out;
    logic            busy;
    logic            done;
    modport master (
        output we, category, index, a_data, b_data, n, mode, start, rd_index,
        input  c_data_out, busy, done
    );
    modport slave (
        input  we, category, index, a_data, b_data, n, mode, start, rd_index,
        output c_data_out, busy, done
    );
endinterface

// File: rtl/vec_mac_engine.sv
// vec_mac_engine: A/B vector memories feeding a 3-stage multiply pipeline that
// either accumulates a dot product or stores elementwise products into C.
module vec_mac_engine #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int ACCW  = 2*DW+16
) (
    input logic      clk,
    input logic      rst,
    vec_mac_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, nxt;
    logic [DW-1:0]   a_mem [DEPTH];
    logic [DW-1:0]   b_mem [DEPTH];
    logic [2*DW-1:0] c_mem [DEPTH];
    logic [AW:0]     cnt, n_eff;
    logic            mode_r, v1, v2;
    logic [AW-1:0]   k1, k2;
    logic [DW-1:0]   ra, rb;
    logic [2*DW-1:0] prod, c_rd;
    logic [ACCW-1:0] acc, c_out;
    logic            idle_like, accept, wr_ok, iss;
    assign idle_like = state == IDLE || state == DONE;
    assign accept    = idle_like && bus.start && !bus.we;
    assign wr_ok     = rst && idle_like && bus.we && ({1'b0, bus.index} < DEPTH_W);
    assign iss       = state == RUN && n_eff != '0;
    assign c_rd      = ({1'b0, bus.rd_index} < DEPTH_W) ? c_mem[bus.rd_index] : '0;
    assign bus.busy       = state == RUN || state == FLUSH;
    assign bus.done       = state == DONE;
    assign bus.c_data_out = c_out;
    always_comb begin
        nxt = state;
        if (accept)
            nxt = RUN;
        else if (state == DONE && bus.we)
            nxt = IDLE;
        else if (state == RUN)
            nxt = n_eff == '0 ? DONE : (cnt == n_eff - ONE ? FLUSH : RUN);
        else if (state == FLUSH && !v1 && !v2)
            nxt = DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            n_eff  <= '0;
            mode_r <= 1'b0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            k1     <= '0;
            k2     <= '0;
            prod   <= '0;
            acc    <= '0;
            c_out  <= '0;
        end else begin
            state <= nxt;
            v1    <= iss;
            k1    <= cnt[AW-1:0];
            v2    <= v1;
            k2    <= k1;
            prod  <= {{DW{1'b0}}, ra} * {{DW{1'b0}}, rb};
            if (iss)
                cnt <= cnt + ONE;
            if (v2 && !mode_r)
                acc <= acc + ACCW'(prod);
            if (accept) begin
                n_eff  <= bus.n > DEPTH_W ? DEPTH_W : bus.n;
                mode_r <= bus.mode;
                cnt    <= '0;
                acc    <= '0;
            end
            // Output tracks readback/result only outside RUN/FLUSH, so it freezes while busy
            if (nxt == IDLE || nxt == DONE)
                c_out <= mode_r ? ACCW'(c_rd) : acc;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_ok && !bus.category)
            a_mem[bus.index] <= bus.a_data;
        if (wr_ok && bus.category)
            b_mem[bus.index] <= bus.b_data;
        if (rst && v2 && mode_r)
            c_mem[k2] <= prod;
        if (iss) begin
            ra <= a_mem[cnt[AW-1:0]];
            rb <= b_mem[cnt[AW-1:0]];
        end
    end
endmodule

// File: tb/tb_vec_mac_engine.sv
// tb_vec_mac_engine: table of runs checked through a result scoreboard,
// plus hand sequences for busy-start, write-while-busy and mid-run reset.
module tb_vec_mac_engine;
    localparam int DW = 16, DEPTH = 20, ACCW = 48, AW = 5, LIMIT = 200;
    typedef struct {int lat; logic [ACCW-1:0] val; logic m;} exp_t;
    typedef struct {logic m; int nn; int lat; logic [ACCW-1:0] val;} vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    vec_t tbl[5];
    vec_mac_if #(.DW(DW), .DEPTH(DEPTH), .ACCW(ACCW)) bus();
    vec_mac_engine #(.DW(DW), .DEPTH(DEPTH), .ACCW(ACCW)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, want);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic cat, input logic [AW-1:0] idx, input logic [DW-1:0] d);
        bus.we = 1'b1;
        bus.category = cat;
        bus.index = idx;
        bus.a_data = d;
        bus.b_data = d;
        tick();
        bus.we = 1'b0;
    endtask
    task automatic rd(input string nm, input logic [AW-1:0] idx, input logic [ACCW-1:0] want);
        bus.rd_index = idx;
        tick();
        chk(nm, bus.c_data_out, want);
    endtask
    task automatic wait_done(input int cyc0);
        int cyc = cyc0;
        exp_t e;
        while (!bus.done && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        e = exp_q.pop_front();
        chk("latency", cyc, e.lat);
        if (!e.m)
            chk("dot_result", bus.c_data_out, e.val);
    endtask
    task automatic pulse_start(input logic m, input int nn);
        bus.start = 1'b1;
        bus.mode = m;
        bus.n = (AW+1)'(nn);
        tick();
        bus.start = 1'b0;
    endtask
    task automatic do_run(input logic m, input int nn, input int lat, input logic [ACCW-1:0] v);
        exp_q.push_back('{lat, v, m});
        pulse_start(m, nn);
        chk("busy_after_start", bus.busy, 1'b1);
        wait_done(0);
    endtask
    initial begin
        tbl[0] = '{1'b0, 16, 19, 48'd16320};
        tbl[1] = '{1'b0, 0, 1, 48'd0};
        tbl[2] = '{1'b1, 16, 19, 48'd0};
        tbl[3] = '{1'b0, 4, 7, 48'd400};
        tbl[4] = '{1'b0, 21, 23, 48'd30800};
        bus.we = 1'b0;
        bus.category = 1'b0;
        bus.index = '0;
        bus.a_data = '0;
        bus.b_data = '0;
        bus.n = '0;
        bus.mode = 1'b0;
        bus.start = 1'b0;
        bus.rd_index = '0;
        repeat (3) tick();
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_done", bus.done, 1'b0);
        chk("reset_out", bus.c_data_out, 48'd0);
        rst = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            wr(1'b0, AW'(k), DW'(10 * (k + 1)));
            wr(1'b1, AW'(k), DW'(k + 2));
        end
        for (int i = 0; i < 5; i++) begin
            do_run(tbl[i].m, tbl[i].nn, tbl[i].lat, tbl[i].val);
            if (tbl[i].m) begin
                rd("rd_c0", 5'd0, 48'd20);
                rd("rd_c15", 5'd15, 48'd2720);
                rd("rd_out_of_range", 5'd25, 48'd0);
            end
        end
        wr(1'b0, 5'd0, 16'd10);
        chk("write_clears_done", bus.done, 1'b0);
        chk("result_held_in_idle", bus.c_data_out, 48'd30800);
        wr(1'b0, 5'd0, 16'hFFFF);
        wr(1'b1, 5'd0, 16'hFFFF);
        exp_q.push_back('{4, 48'd4294836225, 1'b0});
        pulse_start(1'b0, 1);
        bus.we = 1'b1;
        bus.category = 1'b0;
        bus.index = 5'd0;
        bus.a_data = 16'd5;
        tick();
        bus.we = 1'b0;
        wait_done(1);
        do_run(1'b0, 1, 4, 48'd4294836225);
        wr(1'b0, 5'd0, 16'd10);
        wr(1'b1, 5'd0, 16'd2);
        exp_q.push_back('{19, 48'd16320, 1'b0});
        pulse_start(1'b0, 16);
        tick();
        tick();
        pulse_start(1'b1, 0);
        wait_done(3);
        pulse_start(1'b0, 16);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        chk("midrun_reset_busy", bus.busy, 1'b0);
        chk("midrun_reset_done", bus.done, 1'b0);
        chk("midrun_reset_out", bus.c_data_out, 48'd0);
        rst = 1'b1;
        do_run(1'b0, 16, 19, 48'd16320);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
